button_conditioner: RTL

//  Input stage directly upstream of game_logic. Takes raw FPGA push-buttons (left, right, up, down, chop, carry),

---
 rtl/input_pkg.sv | 23 ++
 rtl/btn_debounce.sv | 51 +++++
 rtl/button_conditioner.sv | 125 ++++++++++++
 3 files changed

// File: rtl/input_pkg.sv
// -----------------------------------------------------------------------------
// input_pkg
// Shared definitions for the push-button input stage: button bit positions,
// button count, the per-button vector type and the auto-repeat counter width.
// Bit order: 0 left, 1 right, 2 up, 3 down, 4 chop, 5 carry.
// -----------------------------------------------------------------------------
package input_pkg;

    localparam int NUM_BTN   = 6;

    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_UP    = 2;
    localparam int BTN_DOWN  = 3;
    localparam int BTN_CHOP  = 4;
    localparam int BTN_CARRY = 5;

    // Width of the per-button hold counter (frames held).
    localparam int HOLD_W    = 6;

    typedef logic [NUM_BTN-1:0] btn_vec_t;

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// One-bit synchroniser plus debouncer. The raw input passes a 2-FF
// synchroniser; the stable level only changes after the synchronised value has
// differed from it for DEBOUNCE_CYC consecutive clocks.
//
// Ports:
//   clock  in   system clock
//   reset  in   synchronous, active-high
//   raw    in   asynchronous raw button, active-high
//   level  out  debounced level (latency raw edge -> level: 2 + DEBOUNCE_CYC)
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would collapse the synchroniser chain.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            cnt    <= '0;
            level  <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            if (sync_2 == level) begin
                // Any return to the stable value restarts the qualification.
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
                level <= sync_2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Input stage for game_logic. Synchronises and debounces the raw push-buttons,
// detects the vsync falling edge and, once per frame, latches frame-stable
// button levels plus one-frame press pulses (rising edge or auto-repeat).
//
// Ports:
//   clock        in   system clock
//   reset        in   synchronous, active-high
//   btn_raw      in   [NUM_BTN] asynchronous raw buttons, active-high
//   vsync_in     in   asynchronous vsync from the video timing
//   btn_level    out  [NUM_BTN] debounced levels, clock domain
//   frame_tick   out  1-cycle pulse, registered vsync falling edge
//   frame_btn    out  [NUM_BTN] masked levels latched at frame_tick
//   frame_press  out  [NUM_BTN] rising edge vs previous frame or auto-repeat
// -----------------------------------------------------------------------------
module button_conditioner
    import input_pkg::*;
#(
    parameter int                 DEBOUNCE_CYC = 1_000_000,
    parameter int                 REPEAT_DELAY = 20,
    parameter int                 REPEAT_RATE  = 6,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK  = 6'b001100
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic               vsync_in,
    output logic [NUM_BTN-1:0] btn_level,
    output logic               frame_tick,
    output logic [NUM_BTN-1:0] frame_btn,
    output logic [NUM_BTN-1:0] frame_press
);

    // ---------------------------------------------------------------- debounce
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_debounce (
            .clock (clock),
            .reset (reset),
            .raw   (btn_raw[g]),
            .level (btn_level[g])
        );
    end

    // ------------------------------------------------------ vsync edge detect
    logic vs_sync_1;
    logic vs_sync_2;
    logic vs_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            vs_sync_1  <= 1'b0;
            vs_sync_2  <= 1'b0;
            vs_d       <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            vs_sync_1  <= vsync_in;
            vs_sync_2  <= vs_sync_1;
            vs_d       <= vs_sync_2;
            frame_tick <= vs_d & ~vs_sync_2;
        end
    end

    // ------------------------------------------------ frame sampling / repeat
    btn_vec_t          lvl;
    btn_vec_t          prev_lvl;
    btn_vec_t          press_edge;
    btn_vec_t          repeat_pulse;
    logic [HOLD_W-1:0] hold_cnt  [NUM_BTN];
    logic [HOLD_W-1:0] hold_next [NUM_BTN];

    // Opposing directions cancel; chop and carry together pass through (pause).
    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        lvl = btn_level;
        if (btn_level[BTN_LEFT] && btn_level[BTN_RIGHT]) begin
            lvl[BTN_LEFT]  = 1'b0;
            lvl[BTN_RIGHT] = 1'b0;
        end
        if (btn_level[BTN_UP] && btn_level[BTN_DOWN]) begin
            lvl[BTN_UP]   = 1'b0;
            lvl[BTN_DOWN] = 1'b0;
        end
    end

    assign press_edge = lvl & ~prev_lvl;

    // hold_cnt counts frames the masked level has been high. A repeat fires
    // when it reaches REPEAT_DELAY; the reload value already includes this
    // frame's increment so the next repeat lands exactly REPEAT_RATE frames on.
    always_comb begin
        repeat_pulse = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            hold_next[i] = hold_cnt[i];
            if (!lvl[i]) begin
                hold_next[i] = '0;
            end else if (REPEAT_MASK[i] && (hold_cnt[i] == HOLD_W'(REPEAT_DELAY))) begin
                repeat_pulse[i] = 1'b1;
                hold_next[i]    = HOLD_W'(REPEAT_DELAY - REPEAT_RATE + 1);
            end else if (hold_cnt[i] != '1) begin
                hold_next[i] = hold_cnt[i] + HOLD_W'(1);
            end
        end
    end

    // NOTE: the small hold-counter array is reset along with everything else so
    // no partial-frame repeat state survives a mid-frame reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_btn   <= '0;
            frame_press <= '0;
            prev_lvl    <= '0;
            hold_cnt    <= '{default: '0};
        end else if (frame_tick) begin
            frame_btn   <= lvl;
            frame_press <= press_edge | repeat_pulse;
            prev_lvl    <= lvl;
            hold_cnt    <= hold_next;
        end
    end

endmodule
